// File: rtl/trace_pkg.sv
// Shared types and constants for the spell-trace round controller.
package trace_pkg;

  localparam int unsigned TRACE_W = 16;
  localparam int unsigned COUNT_W = 6;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StLoad  = 3'd1;
  localparam state_t StWait  = 3'd2;
  localparam state_t StAward = 3'd3;
  localparam state_t StDone  = 3'd4;

  localparam logic PlayerP1 = 1'b0;
  localparam logic PlayerP2 = 1'b1;

  localparam logic [COUNT_W-1:0] ScoreMax = '1;

  // Extra traced cells are allowed; every target cell must be covered.
  function automatic logic trace_covers(logic [TRACE_W-1:0] traced,
                                        logic [TRACE_W-1:0] target);
    return (traced & target) == target;
  endfunction

endpackage

// File: rtl/trace_pattern_rom.sv
// Synchronous pattern ROM: one 16-bit target pattern per round, read when en_i is high.
module trace_pattern_rom
  import trace_pkg::*;
#(
  parameter int unsigned NUM_TRACES = 30
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [COUNT_W-1:0] addr_i,
  output logic [TRACE_W-1:0] data_o
);

  logic [TRACE_W-1:0] data_q;

  function automatic logic [TRACE_W-1:0] pattern(logic [COUNT_W-1:0] idx);
    logic [TRACE_W-1:0] p;
    unique case (idx)
      6'd0:    p = 16'h0231;
      6'd1:    p = 16'h0075;
      6'd2:    p = 16'h8ca9;
      6'd3:    p = 16'h8f23;
      6'd4:    p = 16'h1248;
      6'd5:    p = 16'h8421;
      6'd6:    p = 16'hf00f;
      6'd7:    p = 16'h0ff0;
      6'd8:    p = 16'h3c3c;
      6'd9:    p = 16'h6996;
      6'd10:   p = 16'h9009;
      6'd11:   p = 16'h4e72;
      6'd12:   p = 16'h27e4;
      6'd13:   p = 16'hc003;
      6'd14:   p = 16'h0660;
      6'd15:   p = 16'h5a5a;
      6'd16:   p = 16'ha5a5;
      6'd17:   p = 16'h1f80;
      6'd18:   p = 16'h01f8;
      6'd19:   p = 16'hc30c;
      6'd20:   p = 16'h30c3;
      6'd21:   p = 16'h7111;
      6'd22:   p = 16'h888e;
      6'd23:   p = 16'h4bd2;
      6'd24:   p = 16'h2db4;
      6'd25:   p = 16'hf888;
      6'd26:   p = 16'h111f;
      6'd27:   p = 16'h6a56;
      6'd28:   p = 16'h0e70;
      6'd29:   p = 16'hb00d;
      default: p = '0;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= (32'(addr_i) < NUM_TRACES) ? pattern(addr_i) : '0;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/trace_round_ctrl.sv
// Round sequencer: fetches patterns, arbitrates p1/p2 submissions and keeps scores.
// Optional per-round timeout is built only when TRACE_TIMEOUT_EN is defined.
module trace_round_ctrl
  import trace_pkg::*;
#(
  parameter int unsigned NUM_TRACES     = 30,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               two_player_mode,
  input  logic [TRACE_W-1:0] p1_traced,
  input  logic               p1_valid,
  input  logic [TRACE_W-1:0] p2_traced,
  input  logic               p2_valid,
  output logic [TRACE_W-1:0] trace_to_display,
  output logic [COUNT_W-1:0] trace_count,
  output logic               trace_screen_on,
  output logic               round_done,
  output logic               round_winner,
  output logic [COUNT_W-1:0] p1_score,
  output logic [COUNT_W-1:0] p2_score,
  output logic               game_over,
  output logic               end_game_early
);

  localparam logic [COUNT_W-1:0] LastIdx = COUNT_W'(NUM_TRACES - 1);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] p1_score_q, p1_score_d;
  logic [COUNT_W-1:0] p2_score_q, p2_score_d;
  logic               winner_q, winner_d;
  logic               last_win_q, last_win_d;
  logic               mode_q, mode_d;

  logic               game_start;
  logic               p1_elig, p2_elig, any_elig, win;
  logic               timeout;

  trace_pattern_rom #(
    .NUM_TRACES(NUM_TRACES)
  ) u_rom (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (state_q == StLoad),
    .addr_i (count_q),
    .data_o (trace_to_display)
  );

  assign game_start = start && ((state_q == StIdle) || (state_q == StDone));
  assign p1_elig    = p1_valid && trace_covers(p1_traced, trace_to_display);
  assign p2_elig    = p2_valid && mode_q && trace_covers(p2_traced, trace_to_display);
  assign any_elig   = p1_elig || p2_elig;
  // On a tie the player who did not win the previous round takes it.
  assign win        = (p1_elig && p2_elig) ? ~last_win_q : (p2_elig ? PlayerP2 : PlayerP1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    winner_d   = winner_q;
    last_win_d = last_win_q;
    mode_d     = mode_q;
    if (game_start) begin
      state_d    = StLoad;
      count_d    = '0;
      p1_score_d = '0;
      p2_score_d = '0;
      winner_d   = PlayerP1;
      last_win_d = PlayerP2;
      mode_d     = two_player_mode;
    end else begin
      case (state_q)
        StLoad: state_d = StWait;
        StWait: begin
          if (any_elig) begin
            state_d    = StAward;
            winner_d   = win;
            last_win_d = win;
            if (win == PlayerP2) begin
              if (p2_score_q != ScoreMax) p2_score_d = p2_score_q + 1'b1;
            end else begin
              if (p1_score_q != ScoreMax) p1_score_d = p1_score_q + 1'b1;
            end
          end else if (timeout) begin
            state_d = StDone;
          end
        end
        StAward: begin
          if (count_q == LastIdx) begin
            state_d = StDone;
          end else begin
            state_d = StLoad;
            count_d = count_q + 1'b1;
          end
        end
        StIdle, StDone: state_d = state_q;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      p1_score_q <= '0;
      p2_score_q <= '0;
      winner_q   <= PlayerP1;
      last_win_q <= PlayerP2;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      winner_q   <= winner_d;
      last_win_q <= last_win_d;
      mode_q     <= mode_d;
    end
  end

`ifdef TRACE_TIMEOUT_EN
  localparam logic [25:0] TimeoutLast = 26'(TIMEOUT_CYCLES - 1);

  logic [25:0] timer_q;
  logic        early_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != StWait) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign timeout = (state_q == StWait) && (timer_q == TimeoutLast);

  always_ff @(posedge clk) begin
    if (reset || game_start) begin
      early_q <= 1'b0;
    end else if (timeout && !any_elig) begin
      early_q <= 1'b1;
    end
  end

  assign end_game_early = early_q;
`else
  assign timeout        = 1'b0;
  assign end_game_early = 1'b0;
`endif

  assign trace_count     = count_q;
  assign trace_screen_on = (state_q == StWait);
  assign round_done      = (state_q == StAward);
  assign round_winner    = winner_q;
  assign p1_score        = p1_score_q;
  assign p2_score        = p2_score_q;
  assign game_over       = (state_q == StDone);

endmodule
